timer_block: RTL and testbench

TIMER_BLOCK -- requirements
Module: timer_block

---
 rtl/timer_block.sv | 111 +++++++++++
 tb/tb_timer_block.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/timer_block.sv
// timer_block: prescaled up-counter with one-shot / periodic modes, halt
// (pause) control and a one-cycle interrupt pulse on each terminal event.
// Driven by level signals from a register block; all outputs are registered.
module timer_block #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rf_trig_start,
  input  logic        rf_trig_halt,
  input  logic        rf_mode,
  input  logic [31:0] rf_termcount,
  output logic        ro_status,
  output logic [31:0] ro_currcount,
  output logic        timer_done,
  output logic        timer_irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last prescaler value before a tick; PRESCALE=1 makes this 0 (tick every cycle).
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_t      state_r;
  logic        start_q_r;
  logic [15:0] presc_r;
  logic        start_edge_s;
  logic        tick_s;

  assign start_edge_s = rf_trig_start & ~start_q_r;
  assign tick_s       = (presc_r == PRESC_LAST);

  // Timer state machine; status/done are updated together with every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      start_q_r    <= 1'b0;
      presc_r      <= 16'd0;
      ro_currcount <= 32'd0;
      ro_status    <= 1'b0;
      timer_done   <= 1'b0;
      timer_irq    <= 1'b0;
    end else begin
      start_q_r <= rf_trig_start;
      // The interrupt is a pulse: it only survives one cycle after a terminal event.
      timer_irq <= 1'b0;
      if (start_edge_s && !rf_trig_halt) begin
        // A clean start edge restarts from zero regardless of the current state.
        state_r      <= ST_RUN;
        presc_r      <= 16'd0;
        ro_currcount <= 32'd0;
        ro_status    <= 1'b1;
        timer_done   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            ro_status  <= 1'b0;
            timer_done <= 1'b0;
          end
          ST_RUN: begin
            if (rf_trig_halt) begin
              // Freeze count and prescaler; resume picks up exactly here.
              state_r   <= ST_PAUSED;
              ro_status <= 1'b0;
            end else if (tick_s) begin
              presc_r <= 16'd0;
              // >= rather than == so a lowered termcount never waits for a 2^32 wrap.
              if (ro_currcount >= rf_termcount) begin
                timer_irq <= 1'b1;
                if (rf_mode) begin
                  ro_currcount <= 32'd0;
                end else begin
                  state_r    <= ST_DONE;
                  ro_status  <= 1'b0;
                  timer_done <= 1'b1;
                end
              end else begin
                ro_currcount <= ro_currcount + 32'd1;
              end
            end else begin
              presc_r <= presc_r + 16'd1;
            end
          end
          ST_PAUSED: begin
            if (!rf_trig_halt) begin
              state_r   <= ST_RUN;
              ro_status <= 1'b1;
            end else begin
              ro_status <= 1'b0;
            end
          end
          ST_DONE: begin
            ro_status  <= 1'b0;
            timer_done <= 1'b1;
          end
          default: begin
            state_r    <= ST_IDLE;
            ro_status  <= 1'b0;
            timer_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_block.sv
// Scoreboard bench for timer_block: each stimulus cycle pushes the expected
// post-edge outputs; a monitor on the falling edge pops and compares.
module tb_timer_block;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic        mode;
  logic [31:0] term;

  logic        st1, dn1, irq1, st4, dn4, irq4;
  logic [31:0] cnt1, cnt4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        care;
    logic        sel;     // 0: PRESCALE=1 instance, 1: PRESCALE=4 instance
    logic        st;
    logic        dn;
    logic        irq;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  timer_block #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .rf_trig_start(start), .rf_trig_halt(halt),
    .rf_mode(mode), .rf_termcount(term), .ro_status(st1), .ro_currcount(cnt1),
    .timer_done(dn1), .timer_irq(irq1)
  );

  timer_block #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .rf_trig_start(start), .rf_trig_halt(halt),
    .rf_mode(mode), .rf_termcount(term), .ro_status(st4), .ro_currcount(cnt4),
    .timer_done(dn4), .timer_irq(irq4)
  );

  // Monitor: one expectation per clock, compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic        a_st, a_dn, a_irq;
    logic [31:0] a_cnt;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.care) begin
        if (e.sel) begin
          a_st = st4; a_dn = dn4; a_irq = irq4; a_cnt = cnt4;
        end else begin
          a_st = st1; a_dn = dn1; a_irq = irq1; a_cnt = cnt1;
        end
        vectors++;
        if (a_st !== e.st || a_dn !== e.dn || a_irq !== e.irq || a_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL vec%0d p%0d: got status=%b done=%b irq=%b count=%0d, want status=%b done=%b irq=%b count=%0d",
                   vectors, e.sel ? 4 : 1, a_st, a_dn, a_irq, a_cnt, e.st, e.dn, e.irq, e.cnt);
        end
      end
    end
  end

  // Push expected outputs after the coming rising edge, then advance one cycle.
  task automatic cyc(input logic sel, input logic e_st, input logic e_dn,
                     input logic e_irq, input logic [31:0] e_cnt);
    exp_t e;
    e.care = 1'b1;
    e.sel  = sel;
    e.st   = e_st;
    e.dn   = e_dn;
    e.irq  = e_irq;
    e.cnt  = e_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int budget;
    reset = 1'b1; start = 1'b0; halt = 1'b0; mode = 1'b0; term = 32'd3;
    @(negedge clk);
    #1;
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

    // One-shot, termcount=3: 0,1,2,3 then irq with DONE
    reset = 1'b0; start = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
    start = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd3);

    // Start edge during DONE restarts from zero
    start = 1'b1; term = 32'd100;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'(i));

    // Halt at count 7: PAUSED, frozen; a start edge under halt is ignored
    halt = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
    start = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
    start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd7);
    // Release halt: RUN resumes from 7, no retrigger from the held start level
    halt = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd7);
    for (int i = 8; i <= 100; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'(i));

    // Reset at count 100 with start held high
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Start level held across release acts as an edge
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Periodic, termcount=2: 0,1,2,0,... with irq once per 3 cycles
    start = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
    start = 1'b1; mode = 1'b1; term = 32'd2;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int p = 0; p < 3; p++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
    // Lowering termcount to 0 below the count: terminal on every tick
    term = 32'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    mode = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // PRESCALE=4, termcount=1, one-shot: steps every 4 cycles, irq 8 after entry
    reset = 1'b1; start = 1'b0; term = 32'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    start = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 4; i <= 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd1);

    // Drain the scoreboard within a bounded number of cycles
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
